// File: rtl/trex_pkg.sv
//------------------------------------------------------------------------------
// trex_pkg : shared types, default tuning constants and helpers for trex_runner
// Rev 1.0  : initial release
//------------------------------------------------------------------------------
`default_nettype none

package trex_pkg;

  localparam logic [9:0] DEF_X_POS     = 10'd50;
  localparam logic [9:0] DEF_GROUND_Y  = 10'd400;
  localparam logic [9:0] DEF_DUCK_DY   = 10'd17;
  localparam int         DEF_JUMP_V0   = 10;
  localparam int         DEF_GRAVITY   = 1;
  localparam int         DEF_FAST_FALL = 3;
  localparam int         DEF_CUT_V     = 3;
  localparam int         DEF_ANIM_BASE = 12;
  localparam int         DEF_ANIM_MIN  = 4;

  typedef enum logic [2:0] {
    FRAME_WAITING = 3'd0,
    FRAME_RUN1    = 3'd1,
    FRAME_RUN2    = 3'd2,
    FRAME_JUMP    = 3'd3,
    FRAME_DUCK1   = 3'd4,
    FRAME_DUCK2   = 3'd5,
    FRAME_CRASH   = 3'd6
  } frame_t;

  typedef logic [2:0] trex_state_t;

  localparam trex_state_t ST_WAITING = 3'd0;
  localparam trex_state_t ST_RUN     = 3'd1;
  localparam trex_state_t ST_JUMP    = 3'd2;
  localparam trex_state_t ST_DUCK    = 3'd3;
  localparam trex_state_t ST_CRASH   = 3'd4;

  // Faster game speed shortens the leg cycle, but never below min_p ticks.
  function automatic logic [7:0] anim_period(input logic [3:0] speed,
                                             input int base, input int min_p);
    int p;
    p = base - int'(speed);
    if (p < min_p) p = min_p;
    return 8'(p);
  endfunction

endpackage

`default_nettype wire

// File: rtl/trex_runner_if.sv
//------------------------------------------------------------------------------
// trex_runner_if : control inputs and sprite outputs of the runner
// Rev 1.0        : initial release
//------------------------------------------------------------------------------
`default_nettype none

interface trex_runner_if;
  import trex_pkg::*;

  logic        tick;
  logic [3:0]  speed;
  logic        jump;
  logic        duck;
  logic        crash;
  logic        restart;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  frame_t      frame;
  trex_state_t state;
  logic        airborne;

  modport master (
    output tick, speed, jump, duck, crash, restart,
    input  x_pos, y_pos, frame, state, airborne
  );

  modport slave (
    input  tick, speed, jump, duck, crash, restart,
    output x_pos, y_pos, frame, state, airborne
  );

endinterface

`default_nettype wire

// File: rtl/trex_anim.sv
//------------------------------------------------------------------------------
// trex_anim : tick-driven period counter toggling the two-phase leg animation
// Rev 1.0   : initial release
//------------------------------------------------------------------------------
`default_nettype none

module trex_anim
  import trex_pkg::*;
#(
  parameter int ANIM_BASE = DEF_ANIM_BASE,
  parameter int ANIM_MIN  = DEF_ANIM_MIN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       enable,
  input  logic       clear,
  input  logic [3:0] speed,
  output logic       phase
);

  logic [7:0] period;
  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;

  always_comb begin
    period  = anim_period(speed, ANIM_BASE, ANIM_MIN);
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // A pose change restarts the cycle from the first leg frame.
    if (clear) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (tick && enable) begin
      if (cnt_q + 8'd1 >= period) begin
        cnt_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/trex_runner.sv
//------------------------------------------------------------------------------
// trex_runner : runner sprite FSM with jump physics, ducking, crash and frames
// Rev 1.0     : initial release
//------------------------------------------------------------------------------
`default_nettype none

module trex_runner
  import trex_pkg::*;
#(
  parameter logic [9:0] X_POS     = DEF_X_POS,
  parameter logic [9:0] GROUND_Y  = DEF_GROUND_Y,
  parameter logic [9:0] DUCK_DY   = DEF_DUCK_DY,
  parameter int         JUMP_V0   = DEF_JUMP_V0,
  parameter int         GRAVITY   = DEF_GRAVITY,
  parameter int         FAST_FALL = DEF_FAST_FALL,
  parameter int         CUT_V     = DEF_CUT_V,
  parameter int         ANIM_BASE = DEF_ANIM_BASE,
  parameter int         ANIM_MIN  = DEF_ANIM_MIN
) (
  input  logic          clk,
  input  logic          rst_n,
  trex_runner_if.slave  bus
);

  localparam logic signed [7:0]  V0_S     = 8'(JUMP_V0);
  localparam logic signed [7:0]  CUT_S    = 8'(CUT_V);
  localparam logic signed [8:0]  G_STEP   = 9'(GRAVITY);
  localparam logic signed [8:0]  FF_STEP  = 9'(GRAVITY * FAST_FALL);
  localparam logic signed [10:0] GROUND_S = $signed({1'b0, GROUND_Y});
  localparam logic [9:0]         DUCK_Y   = GROUND_Y + DUCK_DY;

  trex_state_t        state_q, state_d;
  logic [9:0]         height_q, height_d;
  logic signed [7:0]  vel_q, vel_d;
  logic signed [7:0]  vel_cap;
  logic signed [10:0] nh;
  logic signed [8:0]  vel_dec;
  logic               in_play;
  logic               anim_phase;

  assign in_play = (state_q == ST_RUN) || (state_q == ST_JUMP) || (state_q == ST_DUCK);

  always_comb begin
    state_d  = state_q;
    height_d = height_q;
    vel_d    = vel_q;
    vel_cap  = vel_q;
    nh       = 11'sd0;
    vel_dec  = 9'sd0;
    // Crash is sampled every clock, not just on frame ticks.
    if (bus.crash && in_play) begin
      state_d = ST_CRASH;
    end else if (bus.tick) begin
      case (state_q)
        ST_WAITING, ST_RUN: begin
          if (bus.jump) begin
            state_d  = ST_JUMP;
            vel_d    = V0_S;
            height_d = 10'd0;
          end else if (state_q == ST_RUN && bus.duck) begin
            state_d = ST_DUCK;
          end
        end
        ST_DUCK: begin
          if (!bus.duck) state_d = ST_RUN;
        end
        ST_JUMP: begin
          if (!bus.jump && vel_q > CUT_S) vel_cap = CUT_S;
          nh = $signed({1'b0, height_q}) + 11'(vel_cap);
          if (nh <= 11'sd0) begin
            height_d = 10'd0;
            vel_d    = 8'sd0;
            state_d  = bus.duck ? ST_DUCK : ST_RUN;
          end else begin
            height_d = (nh > GROUND_S) ? GROUND_Y : nh[9:0];
            vel_dec  = 9'(vel_cap) - (bus.duck ? FF_STEP : G_STEP);
            vel_d    = (vel_dec < -9'sd128) ? -8'sd128 : vel_dec[7:0];
          end
        end
        ST_CRASH: begin
          if (bus.restart) begin
            state_d  = ST_RUN;
            height_d = 10'd0;
            vel_d    = 8'sd0;
          end
        end
        default: state_d = ST_WAITING;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAITING;
      height_q <= 10'd0;
      vel_q    <= 8'sd0;
    end else begin
      state_q  <= state_d;
      height_q <= height_d;
      vel_q    <= vel_d;
    end
  end

  trex_anim #(
    .ANIM_BASE (ANIM_BASE),
    .ANIM_MIN  (ANIM_MIN)
  ) u_anim (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick   (bus.tick),
    .enable ((state_q == ST_RUN) || (state_q == ST_DUCK)),
    .clear  (state_d != state_q),
    .speed  (bus.speed),
    .phase  (anim_phase)
  );

  assign bus.x_pos    = X_POS;
  assign bus.y_pos    = (state_q == ST_DUCK) ? DUCK_Y : (GROUND_Y - height_q);
  assign bus.state    = state_q;
  assign bus.airborne = (height_q != 10'd0) || (state_q == ST_JUMP);

  always_comb begin
    case (state_q)
      ST_RUN:   bus.frame = anim_phase ? FRAME_RUN2 : FRAME_RUN1;
      ST_JUMP:  bus.frame = FRAME_JUMP;
      ST_DUCK:  bus.frame = anim_phase ? FRAME_DUCK2 : FRAME_DUCK1;
      ST_CRASH: bus.frame = FRAME_CRASH;
      default:  bus.frame = FRAME_WAITING;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trex_runner.sv
//------------------------------------------------------------------------------
// tb_trex_runner : directed self-checking bench for trex_runner
// Rev 1.0        : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_trex_runner;
  import trex_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  trex_runner_if bus();

  trex_runner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; tick is a one-clock strobe.
  task automatic step(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
    bus.tick = 1'b0;
  endtask

  task automatic check_pose(input string tag, input logic [2:0] st,
                            input logic [9:0] y, input logic air);
    check_eq({tag, "_state"}, 32'(bus.state), 32'(st));
    check_eq({tag, "_y"}, 32'(bus.y_pos), 32'(y));
    check_eq({tag, "_air"}, 32'(bus.airborne), 32'(air));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int full_h[20];
    int short_h[6];
    int ff_h[6];
    full_h  = '{10, 19, 27, 34, 40, 45, 49, 52, 54, 55,
                55, 54, 52, 49, 45, 40, 34, 27, 19, 10};
    short_h = '{3, 5, 6, 6, 5, 3};
    ff_h    = '{55, 52, 46, 37, 25, 10};
    n_checks = 0;
    n_errors = 0;

    rst_n       = 1'b0;
    bus.tick    = 1'b0;
    bus.speed   = 4'd0;
    bus.jump    = 1'b0;
    bus.duck    = 1'b0;
    bus.crash   = 1'b0;
    bus.restart = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check_pose("rst", ST_WAITING, 10'd400, 1'b0);
    check_eq("rst_frame", 32'(bus.frame), 32'(FRAME_WAITING));
    check_eq("rst_x", 32'(bus.x_pos), 32'd50);

    // Crash is ignored while waiting
    bus.crash = 1'b1;
    step(1'b1);
    check_eq("wait_crash_state", 32'(bus.state), 32'(ST_WAITING));
    bus.crash = 1'b0;

    // Full jump with jump held throughout
    bus.jump = 1'b1;
    step(1'b1);
    check_pose("launch", ST_JUMP, 10'd400, 1'b1);
    check_eq("launch_frame", 32'(bus.frame), 32'(FRAME_JUMP));
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      check_eq($sformatf("full_y%0d", i + 1), 32'(bus.y_pos), 32'(400 - full_h[i]));
    end
    step(1'b1);
    check_pose("full_land", ST_RUN, 10'd400, 1'b0);
    bus.jump = 1'b0;

    // Animation period 6 at speed 6, then 4 at speed 15
    bus.speed = 4'd6;
    check_eq("anim_start", 32'(bus.frame), 32'(FRAME_RUN1));
    repeat (5) step(1'b1);
    check_eq("anim6_t5", 32'(bus.frame), 32'(FRAME_RUN1));
    step(1'b1);
    check_eq("anim6_t6", 32'(bus.frame), 32'(FRAME_RUN2));
    repeat (5) step(1'b1);
    check_eq("anim6_t11", 32'(bus.frame), 32'(FRAME_RUN2));
    step(1'b1);
    check_eq("anim6_t12", 32'(bus.frame), 32'(FRAME_RUN1));
    bus.speed = 4'd15;
    repeat (3) step(1'b1);
    check_eq("anim4_t3", 32'(bus.frame), 32'(FRAME_RUN1));
    step(1'b1);
    check_eq("anim4_t4", 32'(bus.frame), 32'(FRAME_RUN2));

    // Duck from run, jump ignored in duck, release back to run
    bus.duck = 1'b1;
    step(1'b1);
    check_pose("duck", ST_DUCK, 10'd417, 1'b0);
    check_eq("duck_frame", 32'(bus.frame), 32'(FRAME_DUCK1));
    bus.jump = 1'b1;
    step(1'b1);
    check_eq("duck_jump_ign", 32'(bus.state), 32'(ST_DUCK));
    bus.jump = 1'b0;
    bus.duck = 1'b0;
    step(1'b1);
    check_pose("unduck", ST_RUN, 10'd400, 1'b0);
    check_eq("unduck_frame", 32'(bus.frame), 32'(FRAME_RUN1));

    // Short jump: released right after launch
    bus.jump = 1'b1;
    step(1'b1);
    bus.jump = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      check_eq($sformatf("short_y%0d", i + 1), 32'(bus.y_pos), 32'(400 - short_h[i]));
    end
    step(1'b1);
    check_pose("short_land", ST_RUN, 10'd400, 1'b0);

    // Fast fall: duck pressed at the apex
    bus.jump = 1'b1;
    step(1'b1);
    repeat (10) step(1'b1);
    check_eq("ff_peak", 32'(bus.y_pos), 32'd345);
    bus.duck = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1);
      check_eq($sformatf("ff_y%0d", i + 11), 32'(bus.y_pos), 32'(400 - ff_h[i]));
    end
    step(1'b1);
    check_pose("ff_land", ST_DUCK, 10'd417, 1'b0);
    bus.jump = 1'b0;
    bus.duck = 1'b0;
    step(1'b1);
    check_eq("ff_unduck", 32'(bus.state), 32'(ST_RUN));

    // Crash mid-air without a tick, frozen, then restart
    bus.jump = 1'b1;
    step(1'b1);
    repeat (3) step(1'b1);
    bus.crash = 1'b1;
    step(1'b0);
    check_pose("crash", ST_CRASH, 10'd373, 1'b1);
    check_eq("crash_frame", 32'(bus.frame), 32'(FRAME_CRASH));
    step(1'b1);
    check_eq("crash_freeze_y", 32'(bus.y_pos), 32'd373);
    bus.crash   = 1'b0;
    bus.jump    = 1'b0;
    bus.restart = 1'b1;
    step(1'b0);
    check_eq("restart_notick", 32'(bus.state), 32'(ST_CRASH));
    step(1'b1);
    check_pose("restart", ST_RUN, 10'd400, 1'b0);
    check_eq("restart_frame", 32'(bus.frame), 32'(FRAME_RUN1));
    bus.restart = 1'b0;

    // Asynchronous reset in the middle of a jump
    bus.jump = 1'b1;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    check_eq("pre_rst_y", 32'(bus.y_pos), 32'd381);
    #2 rst_n = 1'b0;
    #1;
    check_pose("async_rst", ST_WAITING, 10'd400, 1'b0);
    check_eq("async_rst_frame", 32'(bus.frame), 32'(FRAME_WAITING));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1);
    check_pose("post_rst_launch", ST_JUMP, 10'd400, 1'b1);
    bus.jump = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/trex_runner.md
TREX_RUNNER -- requirements
Module: trex_runner

Interface
REQ-001 Parameters SHALL be: X_POS, default 10'd50, fixed sprite left edge.
REQ-002 Parameter GROUND_Y, default 10'd400, SHALL be the sprite top y when standing.
REQ-003 Parameter DUCK_DY, default 10'd17, SHALL be the y offset added while ducking.
REQ-004 Parameter JUMP_V0, default 10, SHALL be the launch velocity in px/tick.
REQ-005 Parameter GRAVITY, default 1, SHALL be the velocity decrement per tick.
REQ-006 Parameter FAST_FALL, default 3, SHALL multiply GRAVITY while duck is held airborne.
REQ-007 Parameter CUT_V, default 3, SHALL be the velocity cap applied on early jump release.
REQ-008 Parameters ANIM_BASE, default 12, and ANIM_MIN, default 4, SHALL set the animation period in ticks.
REQ-009 Ports SHALL be: clk, input, 1, system clock.
REQ-010 rst_n, input, 1, SHALL be an asynchronous, active-low reset.
REQ-011 tick, input, 1, SHALL be a one-cycle game-frame strobe (60 Hz).
REQ-012 speed, input, 4, SHALL be the game speed level.
REQ-013 jump, duck, crash and restart, input, 1 each, SHALL be level-sensitive controls.
REQ-014 x_pos and y_pos, output, 10 each, SHALL be the sprite top-left position.
REQ-015 frame, output, frame_t, SHALL be the sprite frame select.
REQ-016 state, output, trex_state_t, SHALL be the current FSM state.
REQ-017 airborne, output, 1, SHALL be high while height > 0 or in JUMP.

Function
REQ-018 FSM states SHALL be WAITING, RUN, JUMP, DUCK and CRASH.
REQ-019 Internal state SHALL be height (unsigned 10b, above ground) and vel (signed 8b).
REQ-020 Except crash, all updates SHALL occur only on clock edges with tick=1; outputs are registered, 1-clk latency after tick.
REQ-021 WAITING + tick + jump SHALL launch: go to JUMP, vel=JUMP_V0, height unchanged at 0.
REQ-022 RUN + tick SHALL: on jump, launch as REQ-021; else on duck, go to DUCK.
REQ-023 DUCK + tick with duck low SHALL go to RUN; jump SHALL be ignored while in DUCK.
REQ-024 Each JUMP tick SHALL first cap vel to CUT_V if jump=0 and vel>CUT_V.
REQ-025 The JUMP tick SHALL then compute nh = height + vel in 11b signed.
REQ-026 If nh <= 0, the JUMP tick SHALL land: height=0, vel=0, go to DUCK if duck is held, else RUN.
REQ-027 Otherwise the JUMP tick SHALL set height=nh and vel -= GRAVITY, or GRAVITY*FAST_FALL if duck is held.
REQ-028 vel SHALL saturate at -128.
REQ-029 height SHALL saturate at GROUND_Y, never going above the screen top.
REQ-030 crash=1 in RUN/JUMP/DUCK SHALL go to CRASH on the next clock regardless of tick; crash has priority over all inputs.
REQ-031 crash in WAITING SHALL be ignored.
REQ-032 CRASH SHALL freeze height, vel and position.
REQ-033 CRASH + tick + restart SHALL go to RUN with height=0, vel=0 and the animation counter cleared.
REQ-034 y_pos SHALL be GROUND_Y+DUCK_DY in DUCK, else GROUND_Y-height; x_pos SHALL be X_POS.
REQ-035 The animation period SHALL be max(ANIM_MIN, ANIM_BASE-speed) ticks.
REQ-036 The animation counter SHALL toggle RUN1/RUN2 (DUCK1/DUCK2) at period expiry and SHALL reset on a RUN<->DUCK change.
REQ-037 frame SHALL be WAITING, RUNx, JUMP, DUCKx or CRASH according to state.

Reset
REQ-038 rst_n low SHALL immediately force: state=WAITING, height=0, vel=0, anim counter=0.
REQ-039 Reset outputs SHALL be frame=FRAME_WAITING, x_pos=X_POS, y_pos=GROUND_Y, airborne=0.
REQ-040 Reset mid-jump SHALL abort to the REQ-038/REQ-039 values; deassertion SHALL take effect on the next clk edge.

Structure
REQ-041 trex_pkg SHALL hold frame_t (FRAME_WAITING, RUN1, RUN2, JUMP, DUCK1, DUCK2, CRASH) and trex_state_t.
REQ-042 The parameter defaults SHALL live in trex_pkg as constants.
REQ-043 One sub-module, trex_anim, SHALL hold the period counter and the toggle.

Verification
REQ-044 Full jump: defaults, jump held from launch tick -> heights 10,19,27.. peak 55 (y_pos 345) at air tick 10, land on air tick 21, RUN.
REQ-045 Short jump: jump released after launch -> heights 3,5,6,6,5,3 then land; min y_pos 394.
REQ-046 Fast fall: duck asserted at peak -> descent per tick 3,6,9..; lands in DUCK with y_pos 417.
REQ-047 Crash mid-air without tick -> CRASH next clk, frame=CRASH, y_pos frozen; restart+tick -> RUN, y_pos 400.
REQ-048 Animation: speed=6 in RUN -> frame toggles every 6 ticks; speed=15 -> every 4 ticks.
REQ-049 rst_n pulsed low mid-jump without a clock edge -> outputs immediately take reset values.
